// File: rtl/xc_malu_sched_pkg.sv
// rtl/xc_malu_sched_pkg.sv - shared types and constants for the XCrypto ALU scheduler
package xc_malu_sched_pkg;

  localparam int UOP_W = 14;
  localparam int PW_W  = 5;

  localparam int UOP_DIV    = 0;
  localparam int UOP_DIVU   = 1;
  localparam int UOP_REM    = 2;
  localparam int UOP_REMU   = 3;
  localparam int UOP_MUL    = 4;
  localparam int UOP_MULU   = 5;
  localparam int UOP_MULSU  = 6;
  localparam int UOP_CLMUL  = 7;
  localparam int UOP_PMUL   = 8;
  localparam int UOP_PCLMUL = 9;
  localparam int UOP_MADD   = 10;
  localparam int UOP_MSUB   = 11;
  localparam int UOP_MACC   = 12;
  localparam int UOP_MMUL   = 13;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_RUN   = 4'b0010,
    ST_RESP  = 4'b0100,
    ST_FLUSH = 4'b1000
  } state_e;

  function automatic logic uop_is_onehot(input logic [UOP_W-1:0] uop);
    return (uop != '0) && ((uop & (uop - UOP_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/xc_malu_sched_rr_arb2.sv
// rtl/xc_malu_sched_rr_arb2.sv - two-way round-robin arbiter with its own pointer register
module xc_rr_arb2 (
  input  logic       clock,
  input  logic       resetn,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic ptr_q, ptr_d;

  always_comb begin
    grant = req;
    if (req == 2'b11) grant = ptr_q ? 2'b10 : 2'b01;
    ptr_d = ptr_q;
    // After serving requester 0 the pointer favours 1, and vice versa.
    if (advance && (grant != 2'b00)) ptr_d = grant[0];
  end

  always_ff @(posedge clock) begin
    if (!resetn) ptr_q <= 1'b0;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/xc_malu_sched.sv
// rtl/xc_malu_sched.sv - shares one multi-cycle XCrypto ALU between two requesters
module xc_malu_sched
  import xc_malu_sched_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [2*UOP_W-1:0] req_uop,
  input  logic [2*PW_W-1:0] req_pw,
  input  logic [63:0]       req_rs1,
  input  logic [63:0]       req_rs2,
  input  logic [63:0]       req_rs3,
  input  logic [1:0]        req_kill,
  output logic [1:0]        rsp_valid,
  input  logic [1:0]        rsp_ready,
  output logic [63:0]       rsp_result,
  output logic              rsp_error,
  output logic              malu_valid,
  output logic              malu_flush,
  output logic [UOP_W-1:0]  malu_uop,
  output logic [PW_W-1:0]   malu_pw,
  output logic [31:0]       malu_rs1,
  output logic [31:0]       malu_rs2,
  output logic [31:0]       malu_rs3,
  input  logic [63:0]       malu_result,
  input  logic              malu_ready
);

  localparam int CNT_W = $clog2(TIMEOUT);

  state_e           state_q, state_d;
  logic             owner_q, owner_d;
  logic [UOP_W-1:0] uop_q, uop_d;
  logic [PW_W-1:0]  pw_q, pw_d;
  logic [31:0]      rs1_q, rs1_d, rs2_q, rs2_d, rs3_q, rs3_d;
  logic [63:0]      result_q, result_d;
  logic             error_q, error_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [1:0]       arb_req, grant;
  logic             accept, sel, own_kill;
  logic [UOP_W-1:0] sel_uop;

  assign arb_req   = (state_q == ST_IDLE) ? req_valid : 2'b00;
  assign req_ready = grant;
  assign accept    = |grant;
  assign sel       = grant[1];
  assign sel_uop   = sel ? req_uop[2*UOP_W-1:UOP_W] : req_uop[UOP_W-1:0];
  assign own_kill  = req_kill[owner_q];

  xc_rr_arb2 u_arb (
    .clock   (clock),
    .resetn  (resetn),
    .req     (arb_req),
    .advance (accept),
    .grant   (grant)
  );

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    uop_d      = uop_q;
    pw_d       = pw_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    rs3_d      = rs3_q;
    result_d   = result_q;
    error_d    = error_q;
    cnt_d      = cnt_q;
    rsp_valid  = 2'b00;
    rsp_result = '0;
    rsp_error  = 1'b0;
    malu_valid = 1'b0;
    malu_flush = 1'b0;
    malu_uop   = '0;
    malu_pw    = '0;
    malu_rs1   = '0;
    malu_rs2   = '0;
    malu_rs3   = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          owner_d = sel;
          uop_d   = sel_uop;
          pw_d    = sel ? req_pw[2*PW_W-1:PW_W] : req_pw[PW_W-1:0];
          rs1_d   = sel ? req_rs1[63:32] : req_rs1[31:0];
          rs2_d   = sel ? req_rs2[63:32] : req_rs2[31:0];
          rs3_d   = sel ? req_rs3[63:32] : req_rs3[31:0];
          cnt_d   = '0;
          // Malformed opcodes are answered directly; the ALU never sees them.
          if (uop_is_onehot(sel_uop)) begin
            state_d = ST_RUN;
          end else begin
            result_d = '0;
            error_d  = 1'b1;
            state_d  = ST_RESP;
          end
        end
      end
      ST_RUN: begin
        malu_valid = 1'b1;
        malu_uop   = uop_q;
        malu_pw    = pw_q;
        malu_rs1   = rs1_q;
        malu_rs2   = rs2_q;
        malu_rs3   = rs3_q;
        if (own_kill) begin
          state_d = ST_FLUSH;
        end else if (malu_ready) begin
          result_d = malu_result;
          error_d  = 1'b0;
          state_d  = ST_RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          result_d = '0;
          error_d  = 1'b1;
          state_d  = ST_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: begin
        rsp_valid  = owner_q ? 2'b10 : 2'b01;
        rsp_result = result_q;
        rsp_error  = error_q;
        if (own_kill || rsp_ready[owner_q]) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        malu_flush = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      owner_q  <= 1'b0;
      uop_q    <= '0;
      pw_q     <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      rs3_q    <= '0;
      result_q <= '0;
      error_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      uop_q    <= uop_d;
      pw_q     <= pw_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      rs3_q    <= rs3_d;
      result_q <= result_d;
      error_q  <= error_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_xc_malu_sched.sv
// tb/tb_xc_malu_sched.sv - directed self-checking bench for xc_malu_sched
module tb_xc_malu_sched;
  import xc_malu_sched_pkg::*;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic [1:0]  req_valid = '0, req_ready, req_kill = '0;
  logic [27:0] req_uop = '0;
  logic [9:0]  req_pw = '0;
  logic [63:0] req_rs1 = '0, req_rs2 = '0, req_rs3 = '0;
  logic [1:0]  rsp_valid, rsp_ready = '0;
  logic [63:0] rsp_result, malu_result;
  logic        rsp_error, malu_valid, malu_flush, malu_ready;
  logic [13:0] malu_uop;
  logic [4:0]  malu_pw;
  logic [31:0] malu_rs1, malu_rs2, malu_rs3;

  always #5 clock = ~clock;

  xc_malu_sched #(.TIMEOUT(40)) dut (
    .clock(clock), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_uop(req_uop), .req_pw(req_pw),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rs3(req_rs3), .req_kill(req_kill),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_error(rsp_error),
    .malu_valid(malu_valid), .malu_flush(malu_flush), .malu_uop(malu_uop), .malu_pw(malu_pw),
    .malu_rs1(malu_rs1), .malu_rs2(malu_rs2), .malu_rs3(malu_rs3),
    .malu_result(malu_result), .malu_ready(malu_ready)
  );

  // ALU model: multiplies rs1*rs2 and signals done on its alu_lat-th valid cycle.
  int   run_cnt = 0;
  int   alu_lat = 3;
  logic alu_en = 1'b1;
  always @(posedge clock) run_cnt <= malu_valid ? run_cnt + 1 : 0;
  assign malu_ready  = alu_en && malu_valid && (run_cnt == alu_lat - 1);
  assign malu_result = {32'h0, malu_rs1} * {32'h0, malu_rs2};

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic set_req(input int r, input logic [13:0] uop, input logic [31:0] a, input logic [31:0] b);
    if (r == 0) begin
      req_uop[13:0] = uop; req_rs1[31:0] = a; req_rs2[31:0] = b; req_rs3[31:0] = '0;
    end else begin
      req_uop[27:14] = uop; req_rs1[63:32] = a; req_rs2[63:32] = b; req_rs3[63:32] = '0;
    end
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (rsp_valid == 2'b00 && n < 100) begin
      tick();
      n++;
    end
  endtask

  int n, vcnt;
  logic [31:0] e_rs1, e_rs2;

  initial begin
    // Reset
    tick(); tick();
    check("rst_req_ready", 64'(req_ready), 64'h0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'h0);
    check("rst_malu_valid", 64'(malu_valid), 64'h0);
    check("rst_malu_flush", 64'(malu_flush), 64'h0);
    resetn = 1'b1;
    tick();

    // Mul 3*5 from requester 0, ALU latency 3
    set_req(0, 14'h0010, 32'd3, 32'd5);
    req_valid = 2'b01;
    #1;
    check("mul_req_ready", 64'(req_ready), 64'h1);
    tick();
    req_valid = 2'b00;
    check("mul_malu_valid", 64'(malu_valid), 64'h1);
    check("mul_malu_uop", 64'(malu_uop), 64'h10);
    check("mul_malu_rs1", 64'(malu_rs1), 64'd3);
    check("mul_malu_rs2", 64'(malu_rs2), 64'd5);
    wait_rsp(n);
    check("mul_rsp_latency", 64'(n), 64'd3);
    check("mul_rsp_valid", 64'(rsp_valid), 64'h1);
    check("mul_result", rsp_result, 64'h0000_0000_0000_000F);
    check("mul_error", 64'(rsp_error), 64'h0);
    check("mul_resp_malu_valid", 64'(malu_valid), 64'h0);
    rsp_ready = 2'b01;
    tick();
    rsp_ready = 2'b00;
    check("mul_flush", 64'(malu_flush), 64'h1);
    check("mul_flush_rsp_valid", 64'(rsp_valid), 64'h0);
    tick();
    check("mul_flush_single", 64'(malu_flush), 64'h0);
    req_valid = 2'b01;
    #1;
    check("mul_ready_again", 64'(req_ready), 64'h1);
    req_valid = 2'b00;

    // Arbitration: both valid from reset, responses accepted immediately
    resetn = 1'b0;
    set_req(0, 14'h0010, 32'd2, 32'd7);
    set_req(1, 14'h0020, 32'd4, 32'd9);
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    tick(); tick();
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      e_rs1 = (i % 2 == 1) ? 32'd4 : 32'd2;
      e_rs2 = (i % 2 == 1) ? 32'd9 : 32'd7;
      check("arb_grant", 64'(req_ready), (i % 2 == 1) ? 64'h2 : 64'h1);
      tick();
      check("arb_malu_rs1", 64'(malu_rs1), 64'(e_rs1));
      check("arb_malu_rs2", 64'(malu_rs2), 64'(e_rs2));
      check("arb_malu_uop", 64'(malu_uop), (i % 2 == 1) ? 64'h20 : 64'h10);
      wait_rsp(n);
      check("arb_rsp_valid", 64'(rsp_valid), (i % 2 == 1) ? 64'h2 : 64'h1);
      check("arb_result", rsp_result, (i % 2 == 1) ? 64'd36 : 64'd14);
      tick(); tick();
    end
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    tick();

    // Kill: requester 1 divu 100/7, non-owner kill ignored, owner kill at RUN cycle 5
    alu_en = 1'b0;
    set_req(1, 14'h0002, 32'd100, 32'd7);
    req_valid = 2'b10;
    tick();
    req_valid = 2'b00;
    check("kill_malu_rs1", 64'(malu_rs1), 64'd100);
    check("kill_malu_uop", 64'(malu_uop), 64'h2);
    tick(); tick();
    req_kill = 2'b01;
    tick();
    req_kill = 2'b00;
    check("kill_nonowner_valid", 64'(malu_valid), 64'h1);
    tick();
    req_kill = 2'b10;
    tick();
    req_kill = 2'b00;
    check("kill_flush", 64'(malu_flush), 64'h1);
    check("kill_rsp_valid", 64'(rsp_valid), 64'h0);
    check("kill_malu_valid", 64'(malu_valid), 64'h0);
    tick();
    check("kill_flush_done", 64'(malu_flush), 64'h0);
    check("kill_no_rsp", 64'(rsp_valid), 64'h0);
    req_valid = 2'b10;
    #1;
    check("kill_idle_ready", 64'(req_ready), 64'h2);
    req_valid = 2'b00;

    // Timeout: ALU never ready, TIMEOUT=40
    set_req(0, 14'h0080, 32'd9, 32'd9);
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    n = 0; vcnt = 0;
    while (rsp_valid == 2'b00 && n < 100) begin
      if (malu_valid) vcnt++;
      tick();
      n++;
    end
    check("to_run_cycles", 64'(vcnt), 64'd40);
    check("to_rsp_latency", 64'(n), 64'd40);
    check("to_rsp_valid", 64'(rsp_valid), 64'h1);
    check("to_error", 64'(rsp_error), 64'h1);
    check("to_result", rsp_result, 64'h0);
    rsp_ready = 2'b01;
    tick();
    rsp_ready = 2'b00;
    tick();

    // Backpressure on a mul 6*7 from requester 1
    alu_en = 1'b1;
    set_req(1, 14'h0010, 32'd6, 32'd7);
    req_valid = 2'b10;
    tick();
    req_valid = 2'b00;
    wait_rsp(n);
    req_valid = 2'b11;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_rsp_valid", 64'(rsp_valid), 64'h2);
      check("bp_result", rsp_result, 64'd42);
      check("bp_error", 64'(rsp_error), 64'h0);
      check("bp_flush", 64'(malu_flush), 64'h0);
      check("bp_no_accept", 64'(req_ready), 64'h0);
      tick();
    end
    req_valid = 2'b00;
    rsp_ready = 2'b10;
    tick();
    rsp_ready = 2'b00;
    check("bp_flush_after", 64'(malu_flush), 64'h1);
    tick();

    // Illegal multi-hot opcode from requester 0
    set_req(0, 14'h0003, 32'd1, 32'd1);
    req_valid = 2'b01;
    #1;
    check("ill_req_ready", 64'(req_ready), 64'h1);
    tick();
    req_valid = 2'b00;
    check("ill_malu_valid", 64'(malu_valid), 64'h0);
    check("ill_rsp_valid", 64'(rsp_valid), 64'h1);
    check("ill_error", 64'(rsp_error), 64'h1);
    check("ill_result", rsp_result, 64'h0);
    rsp_ready = 2'b01;
    tick();
    rsp_ready = 2'b00;
    check("ill_flush", 64'(malu_flush), 64'h1);
    check("ill_flush_malu_valid", 64'(malu_valid), 64'h0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/xc_malu_sched.md
# xc_malu_sched

Request scheduler that shares one multi-cycle XCrypto ALU (div/rem, mul variants, clmul, pmul/pclmul, madd/msub/macc/mmul) between two requesters, e.g. the scalar pipeline and the crypto co-processor front end. It arbitrates round-robin and latches the winner's operands. It holds the ALU's `valid` level for the whole operation, captures the 64-bit result and returns it through a per-requester response handshake. It then pulses the ALU's `flush` to return the ALU to its initial state. It also provides per-requester kill, an operation timeout and illegal-opcode rejection.

## Interface
- TIMEOUT, 64: maximum RUN cycles before the operation is abandoned with an error. Minimum 34.
- clock  in  1  clock.
- resetn  in  1  reset, synchronous, active-low.
- req_valid  in  2  per-requester request valid. Bit i belongs to requester i.
- req_ready  out  2  per-requester accept. At most one bit is set.
- req_uop  in  28  two 14-bit one-hot opcodes, requester i at [14i+13:14i]. Bit order: div, divu, rem, remu, mul, mulu, mulsu, clmul, pmul, pclmul, madd, msub, macc, mmul (bit 0 is div).
- req_pw  in  10  two 5-bit pack-width fields, {pw_2, pw_4, pw_8, pw_16, pw_32}.
- req_rs1, req_rs2, req_rs3  in  64 each  two 32-bit operands per field, requester i at [32i+31:32i].
- req_kill  in  2  requester i abandons its outstanding operation.
- rsp_valid  out  2  one-hot response valid.
- rsp_ready  in  2  per-requester response accept.
- rsp_result  out  64  result of the operation.
- rsp_error  out  1  set on timeout or illegal opcode.
- malu_valid  out  1  ALU inputs valid.
- malu_flush  out  1  ALU state flush.
- malu_uop  out  14  registered opcode.
- malu_pw  out  5  registered pack width.
- malu_rs1, malu_rs2, malu_rs3  out  32 each  registered operands.
- malu_result  in  64  ALU result.
- malu_ready  in  1  ALU done.

## Operation
- States: IDLE, RUN, RESP, FLUSH.
- **IDLE**
  - `req_ready[g]` = 1 for the grant g chosen by round-robin among the set `req_valid` bits. All other outputs are 0.
  - Round-robin: the pointer resets to 0. On an accept it moves to the other requester. With a single requester valid, that requester wins.
  - Accept (`req_valid[g] && req_ready[g]`): latch uop, pw, rs1, rs2, rs3 and the owner g.
  - If the opcode is one-hot, go to RUN.
  - If the opcode is zero or multi-hot, go to RESP with error=1 and result=0. The ALU is never started.
- **RUN**
  - `malu_valid` = 1 and `malu_uop`, `malu_pw`, `malu_rs*` are stable for the whole state.
  - The timeout counter starts at 0 and increments each cycle.
  - First cycle with `malu_ready`: capture `malu_result`, set error=0, go to RESP.
  - Counter equal to TIMEOUT-1 without `malu_ready`: result=0, error=1, go to RESP.
- **RESP**
  - `rsp_valid[owner]` = 1. `rsp_result` and `rsp_error` are held stable until the handshake; `malu_valid` = 0.
  - On handshake go to FLUSH.
- **FLUSH**
  - `malu_flush` = 1 for exactly one cycle, then go to IDLE.
- Kill
  - `req_kill[owner]` in RUN or RESP: go to FLUSH and produce no response. This includes an unaccepted `rsp_valid`.
  - Kill from the non-owner, or in IDLE or FLUSH, is ignored.
  - Kill in the same cycle as `malu_ready` or a response handshake: kill wins.
- Reset mid-operation: state goes to IDLE and the pointer to 0. All outputs are 0, including `malu_flush`; the ALU's own reset clears it.

## Timing
- Accept at cycle T. `malu_valid` is high from T+1.
- ALU ready at cycle T+L. `rsp_valid` is high from T+L+1.
- Response handshake at cycle R. `malu_flush` is high at R+1. `req_ready` can be high again at R+2.
- Minimum occupancy is L+3 cycles per operation.
- An illegal opcode accepted at T gives `rsp_valid` at T+1.
- All outputs are registered-state decodes. No combinational path from `req_*` to `malu_*`. `req_ready` depends combinationally only on `req_valid`, the pointer and the state.

## Structure
- Package `xc_malu_sched_pkg` holds:
  - the state encoding (one-hot, 4 bits);
  - UOP_W=14 and PW_W=5;
  - uop bit-index constants, UOP_DIV..UOP_MMUL.
- Sub-module `xc_rr_arb2`: a 2-way round-robin arbiter. Inputs: req[1:0], advance. Outputs: one-hot grant[1:0]. It contains the pointer register.

## Test plan
- Mul: requester 0 sends uop mul, rs1=3, rs2=5; the ALU model asserts ready after 3 RUN cycles with result 15. Required: `rsp_valid`=01, result 0x0000_0000_0000_000F, error 0, one `malu_flush` pulse, `req_ready` again 2 cycles after the handshake.
- Arbitration: both requesters are valid continuously from reset, and every response is accepted immediately. Required: grants in the order 0, 1, 0, 1. Operand registers always match the granted requester.
- Kill: requester 1 sends divu 100/7; `req_kill[1]` is raised at RUN cycle 5. Required: no `rsp_valid`, `malu_flush` the next cycle, then IDLE.
- Timeout: TIMEOUT=40 and the ALU model never asserts ready. Required: `rsp_valid` after exactly 40 RUN cycles, error 1, result 0.
- Illegal opcode: uop 0x0003 from requester 0. Required: `malu_valid` never asserted, `rsp_valid`=01 at T+1, error 1.
- Backpressure: `rsp_ready` is held low for 5 cycles. Required: result and error stable, `malu_flush` 0, no new accept.
